// File: rtl/crc32_msg_sequencer_pkg.sv
// Shared types and constants for the crc32 message sequencer and its packer.
package crc_pkg;

    localparam int CRC_W = 32;
    localparam logic [CRC_W-1:0] CRC32_POLY_DEFAULT = 32'h04C11DB7;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        COMPUTE = 3'd2,
        CAPTURE = 3'd3,
        RESULT  = 3'd4
    } state_t;

endpackage

// File: rtl/crc32_msg_sequencer_if.sv
// Byte-stream input, crc32 core link and result port of the message sequencer.
// Both s_* and m_* are valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; valid never depends combinationally on ready.
interface crc32_msg_sequencer_if #(
    parameter int LEN_W = 16
);
    import crc_pkg::*;

    logic [7:0]       s_data_i;
    logic             s_valid_i;
    logic             s_last_i;
    logic             s_ready_o;
    logic [CRC_W-1:0] core_msg_o;
    logic             core_compute_o;
    logic [CRC_W-1:0] core_poly_o;
    logic [CRC_W-1:0] crc_i;
    logic [CRC_W-1:0] m_crc_o;
    logic [LEN_W-1:0] m_len_o;
    logic             m_valid_o;
    logic             m_ready_i;
    logic             busy_o;
    state_t           state_dbg;

    modport master (
        input  s_data_i, s_valid_i, s_last_i, crc_i, m_ready_i,
        output s_ready_o, core_msg_o, core_compute_o, core_poly_o,
               m_crc_o, m_len_o, m_valid_o, busy_o, state_dbg
    );

    modport slave (
        output s_data_i, s_valid_i, s_last_i, crc_i, m_ready_i,
        input  s_ready_o, core_msg_o, core_compute_o, core_poly_o,
               m_crc_o, m_len_o, m_valid_o, busy_o, state_dbg
    );

endinterface

// File: rtl/crc32_msg_sequencer_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; unfilled bytes stay zero.
module crc32_byte_packer
    import crc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [7:0]       data,
    input  logic             last,
    input  logic             clear,
    output logic [CRC_W-1:0] word,
    output logic             word_done
);

    logic [1:0]       idx_q;
    logic [CRC_W-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else if (clear) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else if (accept) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    word_q[31:24] <= data;
                2'd1:    word_q[23:16] <= data;
                2'd2:    word_q[15:8]  <= data;
                default: word_q[7:0]   <= data;
            endcase
        end
    end

    // Word is complete when the fourth byte or the final byte of the message lands.
    assign word_done = accept && ((idx_q == 2'd3) || last);
    assign word      = word_q;

endmodule

// File: rtl/crc32_msg_sequencer.sv
// Feeds packed message words to a crc32 core, chains the remainder across words
// and presents the final CRC with the message byte length.
module crc32_msg_sequencer
    import crc_pkg::*;
#(
    parameter int               CRC_CYCLES = 32,
    parameter logic [CRC_W-1:0] POLY       = CRC32_POLY_DEFAULT,
    parameter int               LEN_W      = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    crc32_msg_sequencer_if.master bus
);

    localparam int CNT_W = (CRC_CYCLES > 1) ? $clog2(CRC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CRC_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CRC_W-1:0] run_crc_q;
    logic [LEN_W-1:0] len_q;
    logic             last_q;

    logic             in_fill;
    logic             accept;
    logic             word_done;
    logic [CRC_W-1:0] word;
    logic             res_hs;

    assign in_fill = (state_q == IDLE) || (state_q == FILL);
    assign accept  = bus.s_valid_i && in_fill && !rst_i;
    assign res_hs  = (state_q == RESULT) && bus.m_ready_i;

    crc32_byte_packer u_packer (
        .clk       (clk_i),
        .rst       (rst_i),
        .accept    (accept),
        .data      (bus.s_data_i),
        .last      (bus.s_last_i),
        .clear     (state_q == CAPTURE),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = word_done ? COMPUTE : FILL;
                end
            end
            FILL: begin
                if (word_done) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = last_q ? RESULT : FILL;
            end
            RESULT: begin
                if (bus.m_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            run_crc_q <= '0;
            len_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            if (accept && (len_q != '1)) begin
                len_q <= len_q + 1'b1;
            end
            if (word_done) begin
                cnt_q  <= CNT_LOAD;
                last_q <= bus.s_last_i;
            end
            if ((state_q == COMPUTE) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            // Core result is valid in the cycle right after compute drops.
            if (state_q == CAPTURE) begin
                run_crc_q <= bus.crc_i;
            end
            if (res_hs) begin
                run_crc_q <= '0;
                len_q     <= '0;
                last_q    <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.s_ready_o      = in_fill && !rst_i;
        bus.core_compute_o = 1'b0;
        bus.core_msg_o     = '0;
        bus.m_valid_o      = 1'b0;
        bus.m_crc_o        = '0;
        bus.m_len_o        = '0;
        bus.busy_o         = (state_q != IDLE);
        if (state_q == COMPUTE) begin
            bus.core_compute_o = 1'b1;
            bus.core_msg_o     = word ^ run_crc_q;
        end
        if (state_q == RESULT) begin
            bus.m_valid_o = 1'b1;
            bus.m_crc_o   = run_crc_q;
            bus.m_len_o   = len_q;
        end
    end

    assign bus.core_poly_o = POLY;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_crc32_msg_sequencer.sv
// Directed bench for crc32_msg_sequencer with a behavioural crc32 core model.
module tb_crc32_msg_sequencer;
    import crc_pkg::*;

    localparam logic [31:0] P = 32'h04C11DB7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    crc32_msg_sequencer_if #(.LEN_W(16)) bus ();

    crc32_msg_sequencer #(.CRC_CYCLES(32), .POLY(P), .LEN_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // (msg * x^32) mod P with zero init, one shift per message bit
    function automatic logic [31:0] crc_mod(input logic [31:0] msg);
        logic [31:0] r;
        r = msg;
        for (int i = 0; i < 32; i++) begin
            if (r[31]) r = (r << 1) ^ P;
            else       r = r << 1;
        end
        return r;
    endfunction

    logic [31:0] crc_q    = '0;
    logic [31:0] cur_msg  = '0;
    logic [31:0] run_msg  = '0;
    int          cur_len  = 0;
    int          run_len  = 0;
    int          runs     = 0;
    int          unstable = 0;
    logic        comp_d   = 1'b0;

    assign bus.crc_i = crc_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q   <= '0;
            cur_len <= 0;
            run_len <= 0;
            runs    <= 0;
            comp_d  <= 1'b0;
        end else begin
            if (bus.core_compute_o) begin
                if (!comp_d) begin
                    cur_len <= 1;
                    cur_msg <= bus.core_msg_o;
                end else begin
                    cur_len <= cur_len + 1;
                    if (bus.core_msg_o !== cur_msg) unstable <= unstable + 1;
                end
                crc_q <= crc_mod(bus.core_msg_o);
            end else if (comp_d) begin
                run_len <= cur_len;
                run_msg <= cur_msg;
                runs    <= runs + 1;
            end
            comp_d <= bus.core_compute_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_seq(input logic [63:0] bytes, input int n, input bit hold);
        int waits;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = bytes[8*(n-1-i) +: 8];
            bus.s_last_i  = (i == n - 1);
            waits = 0;
            while (!bus.s_ready_o && waits < 400) begin
                @(negedge clk);
                waits++;
            end
            if (waits >= 400) check("send_ready_timeout", 32'(bus.s_ready_o), 32'd1);
            @(posedge clk);
            #1;
            if (i == n - 1 && hold) begin
                bus.s_data_i = 8'hAA;
                bus.s_last_i = 1'b0;
            end else begin
                bus.s_valid_i = 1'b0;
                bus.s_last_i  = 1'b0;
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        int waits;
        waits = 0;
        @(negedge clk);
        while (!bus.m_valid_o && waits < 400) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 400) check({tag, "_valid_timeout"}, 32'(bus.m_valid_o), 32'd1);
        bus.s_valid_i = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.m_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.m_ready_i = 1'b0;
        @(negedge clk);
        check({tag, "_valid_after_hs"}, 32'(bus.m_valid_o), 32'd0);
        check({tag, "_busy_after_hs"}, 32'(bus.busy_o), 32'd0);
    endtask

    task automatic result(input string tag, input logic [31:0] exp_crc, input logic [31:0] exp_len);
        wait_valid(tag);
        check({tag, "_crc"}, bus.m_crc_o, exp_crc);
        check({tag, "_len"}, 32'(bus.m_len_o), exp_len);
        handshake(tag);
    endtask

    initial begin
        int base;
        int ncomp;
        logic [31:0] exp_crc;

        bus.s_data_i  = '0;
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        bus.m_ready_i = 1'b0;

        // reset values while reset is held
        @(negedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
        check("rst_compute", 32'(bus.core_compute_o), 32'd0);
        check("rst_msg", bus.core_msg_o, 32'd0);
        check("rst_poly", bus.core_poly_o, 32'h04C11DB7);
        check("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
        check("rst_m_crc", bus.m_crc_o, 32'd0);
        check("rst_m_len", 32'(bus.m_len_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", 32'(bus.s_ready_o), 32'd1);

        // 1: single full word 00 00 00 01
        base = runs;
        send_seq(64'h00000001, 4, 1'b0);
        wait_valid("t1");
        check("t1_runs", 32'(runs - base), 32'd1);
        check("t1_run_len", 32'(run_len), 32'd32);
        check("t1_run_msg", run_msg, 32'h00000001);
        check("t1_crc", bus.m_crc_o, 32'h04C11DB7);
        check("t1_len", 32'(bus.m_len_o), 32'd4);
        handshake("t1");

        // 2: two words, remainder of zero word chains into the second
        base = runs;
        send_seq(64'h00000000_00000001, 8, 1'b0);
        wait_valid("t2");
        check("t2_runs", 32'(runs - base), 32'd2);
        check("t2_run_len", 32'(run_len), 32'd32);
        check("t2_run_msg", run_msg, 32'h00000001);
        check("t2_crc", bus.m_crc_o, 32'h04C11DB7);
        check("t2_len", 32'(bus.m_len_o), 32'd8);
        handshake("t2");

        // 3: single byte, zero-padded word
        base = runs;
        send_seq(64'hFF, 1, 1'b0);
        wait_valid("t3");
        check("t3_runs", 32'(runs - base), 32'd1);
        check("t3_run_msg", run_msg, 32'hFF000000);
        check("t3_crc", bus.m_crc_o, crc_mod(32'hFF000000));
        check("t3_len", 32'(bus.m_len_o), 32'd1);
        handshake("t3");

        // 4: result held while m_ready stays low
        exp_crc = crc_mod(32'hFFEEFFEE);
        send_seq(64'hFFEEFFEE, 4, 1'b0);
        wait_valid("t4");
        for (int i = 0; i < 20; i++) begin
            check("t4_hold_valid", 32'(bus.m_valid_o), 32'd1);
            check("t4_hold_crc", bus.m_crc_o, exp_crc);
            check("t4_hold_len", 32'(bus.m_len_o), 32'd4);
            check("t4_hold_s_ready", 32'(bus.s_ready_o), 32'd0);
            @(negedge clk);
        end
        handshake("t4");
        check("t4_s_ready_after", 32'(bus.s_ready_o), 32'd1);

        // 5: asynchronous reset in the tenth COMPUTE cycle
        send_seq(64'h00000001, 4, 1'b0);
        ncomp = 0;
        for (int i = 0; i < 60 && ncomp < 10; i++) begin
            @(negedge clk);
            if (bus.core_compute_o) ncomp++;
        end
        check("t5_reached_cycle10", 32'(ncomp), 32'd10);
        rst = 1'b1;
        #1;
        check("t5_compute_drop", 32'(bus.core_compute_o), 32'd0);
        check("t5_msg_zero", bus.core_msg_o, 32'd0);
        check("t5_m_valid", 32'(bus.m_valid_o), 32'd0);
        check("t5_busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_s_ready_after_rst", 32'(bus.s_ready_o), 32'd1);
        base = runs;
        send_seq(64'h00000001, 4, 1'b0);
        wait_valid("t5");
        check("t5_runs", 32'(runs - base), 32'd1);
        check("t5_run_len", 32'(run_len), 32'd32);
        check("t5_crc", bus.m_crc_o, 32'h04C11DB7);
        check("t5_len", 32'(bus.m_len_o), 32'd4);
        handshake("t5");

        // 6: s_valid kept high through COMPUTE/CAPTURE is not consumed
        base = runs;
        send_seq(64'h00000001, 4, 1'b1);
        wait_valid("t6");
        check("t6_runs", 32'(runs - base), 32'd1);
        check("t6_crc", bus.m_crc_o, 32'h04C11DB7);
        check("t6_len", 32'(bus.m_len_o), 32'd4);
        handshake("t6");

        // 7: partial final word after a full one reports true length
        base = runs;
        exp_crc = crc_mod(crc_mod(32'h12345678) ^ 32'h9A000000);
        send_seq(64'h123456789A, 5, 1'b0);
        wait_valid("t7");
        check("t7_runs", 32'(runs - base), 32'd2);
        check("t7_run_msg", run_msg, crc_mod(32'h12345678) ^ 32'h9A000000);
        check("t7_crc", bus.m_crc_o, exp_crc);
        check("t7_len", 32'(bus.m_len_o), 32'd5);
        handshake("t7");

        check("msg_stability", 32'(unstable), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
